// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the 16x16 register file: buffers write requests,
// issues one register write per cycle and forwards the youngest pending data.
module regfile_writeback_queue #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 4,
    parameter int DROP_R0 = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WB_VALID,
    output logic              WB_READY,
    input  logic [ADDR_W-1:0] WB_RD,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic              STALL,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] REGDATA,
    output logic              REGWRITE,
    input  logic [ADDR_W-1:0] LOOKUP_ADDR,
    output logic              LOOKUP_HIT,
    output logic [DATA_W-1:0] LOOKUP_DATA,
    output logic [ADDR_W-1:0] COUNT,
    output logic              EMPTY,
    output logic              FULL
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_dropReq;
    logic              w_push;
    logic              w_lookupHit;
    logic [DATA_W-1:0] w_lookupData;
    logic [PTR_W-1:0]  w_idx;
    logic              w_lookupR0;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = !w_empty && !STALL;
    assign w_accept  = WB_VALID && (!w_full || w_pop);
    assign w_dropReq = (DROP_R0 != 0) && (WB_RD == '0);
    // A dropped R0 request completes its handshake but never occupies a slot.
    assign w_push    = w_accept && !w_dropReq;

    assign WB_READY  = !w_full || w_pop;
    assign REGWRITE  = w_pop;
    assign RD        = w_empty ? '0 : r_addr[r_rdPtr];
    assign REGDATA   = w_empty ? '0 : r_data[r_rdPtr];
    assign COUNT     = ADDR_W'(r_count);
    assign EMPTY     = w_empty;
    assign FULL      = w_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wrPtr] <= WB_RD;
                r_data[r_wrPtr] <= WB_DATA;
                r_wrPtr         <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    assign w_lookupR0 = (DROP_R0 != 0) && (LOOKUP_ADDR == '0);

    always_comb begin
        w_lookupHit  = 1'b0;
        w_lookupData = '0;
        w_idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rdPtr + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr[w_idx] == LOOKUP_ADDR) && !w_lookupR0) begin
                w_lookupHit  = 1'b1;
                w_lookupData = r_data[w_idx];
            end
        end
    end

    assign LOOKUP_HIT  = w_lookupHit;
    assign LOOKUP_DATA = w_lookupData;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: a table of per-cycle vectors with
// hand-computed outputs, plus hand-written reset-abort and commit-order sequences.
module tb_regfile_writeback_queue;

    logic        CLK;
    logic        RST_N;
    logic        WB_VALID;
    logic        WB_READY;
    logic [3:0]  WB_RD;
    logic [15:0] WB_DATA;
    logic        STALL;
    logic [3:0]  RD;
    logic [15:0] REGDATA;
    logic        REGWRITE;
    logic [3:0]  LOOKUP_ADDR;
    logic        LOOKUP_HIT;
    logic [15:0] LOOKUP_DATA;
    logic [3:0]  COUNT;
    logic        EMPTY;
    logic        FULL;

    regfile_writeback_queue #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(4), .DROP_R0(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .STALL(STALL),
        .RD(RD), .REGDATA(REGDATA), .REGWRITE(REGWRITE),
        .LOOKUP_ADDR(LOOKUP_ADDR), .LOOKUP_HIT(LOOKUP_HIT), .LOOKUP_DATA(LOOKUP_DATA),
        .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v;
        logic [3:0]  rd;
        logic [15:0] dat;
        logic        st;
        logic [3:0]  la;
        logic        eRdy;
        logic        eWe;
        logic [3:0]  eRd;
        logic [15:0] eDat;
        logic        eHit;
        logic [15:0] eLd;
        logic [3:0]  eCnt;
    } vec_t;

    vec_t        vecs [24];
    int          applied = 0;
    int          miscompares = 0;
    logic [19:0] commits [$];
    logic [15:0] regModel [16];

    function automatic vec_t mk(input logic v, input logic [3:0] rd, input logic [15:0] dat,
                                input logic st, input logic [3:0] la,
                                input logic eRdy, input logic eWe, input logic [3:0] eRd,
                                input logic [15:0] eDat, input logic eHit,
                                input logic [15:0] eLd, input logic [3:0] eCnt);
        vec_t r;
        r = {v, rd, dat, st, la, eRdy, eWe, eRd, eDat, eHit, eLd, eCnt};
        return r;
    endfunction

    // Drive inputs right after a falling edge, then let them settle.
    task automatic applyStimulus(input logic v, input logic [3:0] rd, input logic [15:0] dat,
                                 input logic st, input logic [3:0] la);
        @(negedge CLK);
        WB_VALID    = v;
        WB_RD       = rd;
        WB_DATA     = dat;
        STALL       = st;
        LOOKUP_ADDR = la;
        #1;
        if (REGWRITE === 1'b1) begin
            commits.push_back({RD, REGDATA});
            regModel[RD] = REGDATA;
        end
    endtask

    task automatic checkOutput(input string name, input vec_t e);
        logic [57:0] act;
        logic [57:0] exp;
        act = {WB_READY, REGWRITE, RD, REGDATA, LOOKUP_HIT, LOOKUP_DATA, COUNT, EMPTY, FULL};
        exp = {e.eRdy, e.eWe, e.eRd, e.eDat, e.eHit, e.eLd, e.eCnt,
               (e.eCnt == 4'd0), (e.eCnt == 4'd4)};
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got rdy/we/rd/data/hit/ld/cnt/empty/full=%h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        applied++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    initial begin
        logic [19:0] expCommits [8];

        WB_VALID = 0; WB_RD = 0; WB_DATA = 0; STALL = 0; LOOKUP_ADDR = 0;
        for (int i = 0; i < 16; i++) regModel[i] = '0;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        //            v  rd  dat  st la   rdy we rd  dat  hit ld  cnt
        vecs[0]  = mk(0, 0,  0,   0, 1,   1, 0, 0,  0,   0, 0,  0);
        vecs[1]  = mk(1, 1,  50,  0, 1,   1, 0, 0,  0,   0, 0,  0);
        vecs[2]  = mk(0, 0,  0,   0, 1,   1, 1, 1,  50,  1, 50, 1);
        vecs[3]  = mk(0, 0,  0,   0, 1,   1, 0, 0,  0,   0, 0,  0);
        vecs[4]  = mk(1, 2,  10,  1, 2,   1, 0, 0,  0,   0, 0,  0);
        vecs[5]  = mk(1, 3,  20,  1, 2,   1, 0, 2,  10,  1, 10, 1);
        vecs[6]  = mk(1, 4,  30,  1, 3,   1, 0, 2,  10,  1, 20, 2);
        vecs[7]  = mk(1, 5,  40,  1, 5,   1, 0, 2,  10,  0, 0,  3);
        vecs[8]  = mk(1, 9,  99,  1, 5,   0, 0, 2,  10,  1, 40, 4);
        vecs[9]  = mk(1, 6,  60,  0, 6,   1, 1, 2,  10,  0, 0,  4);
        vecs[10] = mk(0, 0,  0,   0, 6,   1, 1, 3,  20,  1, 60, 4);
        vecs[11] = mk(0, 0,  0,   0, 6,   1, 1, 4,  30,  1, 60, 3);
        vecs[12] = mk(0, 0,  0,   0, 6,   1, 1, 5,  40,  1, 60, 2);
        vecs[13] = mk(0, 0,  0,   0, 6,   1, 1, 6,  60,  1, 60, 1);
        vecs[14] = mk(0, 0,  0,   0, 6,   1, 0, 0,  0,   0, 0,  0);
        vecs[15] = mk(1, 7,  1,   1, 7,   1, 0, 0,  0,   0, 0,  0);
        vecs[16] = mk(1, 7,  2,   1, 7,   1, 0, 7,  1,   1, 1,  1);
        vecs[17] = mk(0, 0,  0,   1, 7,   1, 0, 7,  1,   1, 2,  2);
        vecs[18] = mk(0, 0,  0,   1, 8,   1, 0, 7,  1,   0, 0,  2);
        vecs[19] = mk(0, 0,  0,   0, 7,   1, 1, 7,  1,   1, 2,  2);
        vecs[20] = mk(0, 0,  0,   0, 7,   1, 1, 7,  2,   1, 2,  1);
        vecs[21] = mk(0, 0,  0,   0, 7,   1, 0, 0,  0,   0, 0,  0);
        vecs[22] = mk(1, 0,  75,  0, 0,   1, 0, 0,  0,   0, 0,  0);
        vecs[23] = mk(0, 0,  0,   0, 0,   1, 0, 0,  0,   0, 0,  0);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].v, vecs[i].rd, vecs[i].dat, vecs[i].st, vecs[i].la);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Every queued request is written exactly once, strictly in order.
        expCommits[0] = {4'd1, 16'd50};
        expCommits[1] = {4'd2, 16'd10};
        expCommits[2] = {4'd3, 16'd20};
        expCommits[3] = {4'd4, 16'd30};
        expCommits[4] = {4'd5, 16'd40};
        expCommits[5] = {4'd6, 16'd60};
        expCommits[6] = {4'd7, 16'd1};
        expCommits[7] = {4'd7, 16'd2};
        checkValue("commitCount", commits.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < commits.size())
                checkValue($sformatf("commit%0d", i), {12'd0, commits[i]}, {12'd0, expCommits[i]});
        end
        checkValue("regR1", {16'd0, regModel[1]}, 50);
        checkValue("regR7", {16'd0, regModel[7]}, 2);
        checkValue("regR0", {16'd0, regModel[0]}, 0);

        // Reset abort: three stalled entries are lost on an asynchronous reset.
        applyStimulus(1, 4'd10, 16'h0A0A, 1, 4'd11);
        applyStimulus(1, 4'd11, 16'h0B0B, 1, 4'd11);
        applyStimulus(1, 4'd12, 16'h0C0C, 1, 4'd11);
        applyStimulus(0, 4'd0, 16'd0, 1, 4'd11);
        checkOutput("preReset", mk(0, 0, 0, 0, 0, 1, 0, 4'd10, 16'h0A0A, 1, 16'h0B0B, 3));
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("inReset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        STALL = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("heldReset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST_N = 1'b1;
        applyStimulus(0, 4'd0, 16'd0, 0, 4'd11);
        checkOutput("postReset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        checkValue("noWriteAfterReset", commits.size(), 8);

        applyStimulus(1, 4'd1, 16'd99, 0, 4'd1);
        checkOutput("pushR1", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 4'd0, 16'd0, 0, 4'd1);
        checkOutput("issueR1", mk(0, 0, 0, 0, 0, 1, 1, 4'd1, 16'd99, 1, 16'd99, 1));
        applyStimulus(0, 4'd0, 16'd0, 0, 4'd1);
        checkOutput("drainR1", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        checkValue("regR1After", {16'd0, regModel[1]}, 99);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side companion to the 16x16 register file: buffers write-back requests from the execute/memory stages and drives the register file's RD / REGDATA / REGWRITE port, one write per cycle.
- Stalls producers only when the queue is full.
- Provides a youngest-match lookup so read stages can forward pending data not yet committed to the register file.
- Sits between the pipeline write-back mux and the registerfile instance.

Parameters:
- DATA_W, 16, width of register data
- ADDR_W, 4, register address width (16 registers)
- DEPTH, 4, queue entries; power of two, at least 2
- DROP_R0, 1, when 1, requests addressed to register 0 are accepted but discarded (never queued, never written)

Ports:
- CLK  input  1  rising-edge clock, shared with the register file
- RST_N  input  1  asynchronous active-low reset
- WB_VALID  input  1  producer has a write request this cycle
- WB_READY  output  1  queue accepts the request this cycle
- WB_RD  input  ADDR_W  destination register of the request
- WB_DATA  input  DATA_W  data of the request
- STALL  input  1  when 1, hold the head entry and issue no write
- RD  output  ADDR_W  to registerfile RD
- REGDATA  output  DATA_W  to registerfile REGDATA
- REGWRITE  output  1  to registerfile REGWRITE
- LOOKUP_ADDR  input  ADDR_W  register being read by the decode stage
- LOOKUP_HIT  output  1  a queued entry targets LOOKUP_ADDR
- LOOKUP_DATA  output  DATA_W  data of the youngest matching queued entry
- COUNT  output  ADDR_W  number of valid entries, 0..DEPTH
- EMPTY  output  1  COUNT==0
- FULL  output  1  COUNT==DEPTH

Behaviour:
- Reset: RST_N low clears the queue asynchronously, regardless of CLK or any in-flight handshake.
  - COUNT=0, EMPTY=1, FULL=0, REGWRITE=0, RD=0, REGDATA=0, LOOKUP_HIT=0, LOOKUP_DATA=0.
  - Pending entries are lost; no partial write is issued.
- Storage: circular buffer with read pointer, write pointer and count, all updated on the rising CLK edge.
- Issue (combinational from the head entry):
  - REGWRITE = !EMPTY && !STALL.
  - RD and REGDATA show the head entry when !EMPTY; they are 0 when EMPTY.
- Pop: at an edge where REGWRITE=1, the head is removed. The register file samples the same edge, so each entry is written exactly once.
- Accept: WB_READY = !FULL || REGWRITE, so push-while-full is allowed when a pop happens in the same cycle. A push occurs at an edge where WB_VALID && WB_READY.
- Latency: a request pushed into an empty, unstalled queue at edge N drives REGWRITE during cycle N..N+1 and is committed to the register file at edge N+1.
- Simultaneous push and pop: COUNT is unchanged and both pointers advance.
- Empty queue: pop never occurs. A push into an empty queue is not bypassed to the outputs in the same cycle.
- DROP_R0=1 with WB_RD==0:
  - WB_READY behaves normally; the handshake completes.
  - Nothing is stored, and COUNT does not change.
- Ordering: strictly FIFO; multiple entries to the same register are all written, in order.
- Lookup (combinational):
  - Compares LOOKUP_ADDR against all valid entries. The youngest (closest to the write pointer) match wins.
  - Entries committing this cycle still count as matches.
  - On no match: LOOKUP_HIT=0, LOOKUP_DATA=0.
  - With DROP_R0=1, LOOKUP_ADDR=0 never hits.
- Pointer wrap: pointers wrap modulo DEPTH. COUNT, not pointer equality, distinguishes full from empty.
- STALL held indefinitely: the queue fills to DEPTH, then WB_READY=0 until STALL deasserts.
- Protocol: inputs are sampled only at the handshake edge. WB_RD and WB_DATA may change freely while WB_READY=0.

Test Plan:
- Reset, then push (R1, 50) at edge 1 with STALL=0 -> REGWRITE=1, RD=1, REGDATA=50 during the next cycle; register file R1 reads 50 afterwards; EMPTY=1 after edge 2.
- STALL=1, push (R2,10), (R3,20), (R4,30), (R5,40) -> FULL=1, COUNT=4, WB_READY=0, REGWRITE=0. Release STALL -> four consecutive writes R2..R5 in order; WB_READY=1 from the first pop cycle.
- Full queue with STALL=0 and WB_VALID=1 (R6,60) -> push and pop occur on the same edge, COUNT stays 4, and R6 is written last.
- Queue holds (R7,1) then (R7,2) and LOOKUP_ADDR=7 -> LOOKUP_HIT=1, LOOKUP_DATA=2. LOOKUP_ADDR=8 -> LOOKUP_HIT=0, LOOKUP_DATA=0.
- DROP_R0=1: push (R0,75) -> WB_READY=1, COUNT stays 0, REGWRITE never asserts, LOOKUP_ADDR=0 gives LOOKUP_HIT=0.
- Three entries queued with STALL=1; pulse RST_N low mid-cycle -> COUNT=0 and REGWRITE=0 immediately, with no write after release. A new push (R1,99) then commits normally.
